// File: rtl/rv_hazard_ctrl.sv
// Pipeline hazard unit: load-use and mul/div interlocks, branch flush priority, stall counter.
// Stall/flush outputs are combinational (0 cycles); mdu_done is registered, max(mdu_lat,1) cycles after issue.
module rv_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rsD1,
    input  logic [4:0]  rsD2,
    input  logic [4:0]  rdE,
    input  logic        mem_readE,
    input  logic        mdu_reqD,
    input  logic        mdu_startE,
    input  logic [3:0]  mdu_lat,
    input  logic        branch_takenE,
    output logic        stallF,
    output logic        stallD,
    output logic        flushD,
    output logic        flushE,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [15:0] stall_cnt
);

    typedef enum logic {IDLE, MDU_BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  mdu_rd_q, mdu_rd_d;
    logic        done_q, done_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic load_hz;
    logic mdu_hz;

    always_comb begin
        load_hz = mem_readE && (rdE != 5'd0) && ((rdE == rsD1) || (rdE == rsD2));
        mdu_hz  = (state_q == MDU_BUSY) &&
                  (((mdu_rd_q != 5'd0) && ((mdu_rd_q == rsD1) || (mdu_rd_q == rsD2))) || mdu_reqD);
    end

    // A taken branch squashes both younger stages, so it overrides any interlock.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (branch_takenE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (load_hz || mdu_hz) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mdu_rd_d = mdu_rd_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mdu_startE) begin
                    cnt_d    = (mdu_lat == 4'd0) ? 4'd1 : mdu_lat;
                    mdu_rd_d = rdE;
                    state_d  = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                // New issues are ignored here; the in-flight op survives branch flushes.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallD && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            mdu_rd_q    <= 5'd0;
            done_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mdu_rd_q    <= mdu_rd_d;
            done_q      <= done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mdu_busy  = (state_q == MDU_BUSY);
    assign mdu_done  = done_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Bench for rv_hazard_ctrl: directed literal scenarios, randomized traffic, deadline-based reference model.
module tb_rv_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rsD1, rsD2, rdE;
    logic        mem_readE, mdu_reqD, mdu_startE, branch_takenE;
    logic [3:0]  mdu_lat;
    logic        stallF, stallD, flushD, flushE, mdu_busy, mdu_done;
    logic [15:0] stall_cnt;

    int checks = 0;
    int passes = 0;

    rv_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rsD1(rsD1), .rsD2(rsD2), .rdE(rdE),
        .mem_readE(mem_readE), .mdu_reqD(mdu_reqD), .mdu_startE(mdu_startE),
        .mdu_lat(mdu_lat), .branch_takenE(branch_takenE),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an op in flight is just "active until absolute edge m_done_edge".
    int   n = 0;
    int   m_done_edge = 0;
    int   m_sc = 0;
    logic m_act = 1'b0;
    logic m_done = 1'b0;
    logic [4:0] m_rd = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] exp_ctl(input logic act);
        logic ld, mh;
        ld = mem_readE && (rdE != 0) && ((rdE == rsD1) || (rdE == rsD2));
        mh = act && (((m_rd != 0) && ((m_rd == rsD1) || (m_rd == rsD2))) || mdu_reqD);
        if (branch_takenE) return 4'b0011;
        if (ld || mh)      return 4'b1101;
        return 4'b0000;
    endfunction

    always @(posedge clk) begin
        logic [3:0] c;
        if (!rst_n) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
            m_sc   <= 0;
        end else begin
            c = exp_ctl(m_act);
            if (c[2] && m_sc < 65535) m_sc <= m_sc + 1;
            if (m_act && n == m_done_edge) begin
                m_act  <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
                if (!m_act && mdu_startE) begin
                    m_act       <= 1'b1;
                    m_done_edge <= n + ((mdu_lat == 0) ? 1 : int'(mdu_lat));
                    m_rd        <= rdE;
                end
            end
        end
        n <= n + 1;
    end

    always @(negedge clk) begin
        logic a;
        a = rst_n ? m_act : 1'b0;
        chk("ctl", {28'd0, stallF, stallD, flushD, flushE}, {28'd0, exp_ctl(a)});
        chk("busy", {31'd0, mdu_busy}, {31'd0, a});
        chk("done", {31'd0, mdu_done}, {31'd0, rst_n ? m_done : 1'b0});
        chk("stall_cnt", {16'd0, stall_cnt}, rst_n ? m_sc : 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clr();
        rsD1 = 0; rsD2 = 0; rdE = 0; mem_readE = 0; mdu_reqD = 0;
        mdu_startE = 0; mdu_lat = 0; branch_takenE = 0;
    endtask

    function automatic logic [31:0] ctl();
        return {28'd0, stallF, stallD, flushD, flushE};
    endfunction

    initial begin
        clr();
        rst_n = 1'b0;
        mid();
        chk("rst_busy", {31'd0, mdu_busy}, 0);
        chk("rst_done", {31'd0, mdu_done}, 0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Load-use
        mem_readE = 1; rdE = 5; rsD1 = 5; rsD2 = 9;
        mid(); chk("lu_ctl", ctl(), 32'hD);
        tick(); clr();
        mid(); chk("lu_cnt", {16'd0, stall_cnt}, 1); chk("lu_clear", ctl(), 0);

        // x0 is never a hazard
        mem_readE = 1; rdE = 0; rsD1 = 3; rsD2 = 0;
        mid(); chk("x0_ctl", ctl(), 0);
        tick(); clr();

        // mul/div latency 4 to rd 7
        mdu_startE = 1; rdE = 7; mdu_lat = 4;
        tick(); clr();
        mid(); chk("mdu_busy_t0", {31'd0, mdu_busy}, 1);
        for (int k = 1; k <= 3; k++) begin
            tick(); clr();
            if (k == 1) rsD1 = 7;
            if (k == 2) rsD1 = 8;
            if (k == 3) mdu_reqD = 1;
            mid();
            chk("mdu_busy", {31'd0, mdu_busy}, 1);
            chk("mdu_done_early", {31'd0, mdu_done}, 0);
            chk("mdu_ctl", ctl(), (k == 2) ? 32'h0 : 32'hD);
        end
        tick(); clr(); rsD1 = 7;
        mid();
        chk("mdu_done_t4", {31'd0, mdu_done}, 1);
        chk("mdu_idle_t4", {31'd0, mdu_busy}, 0);
        chk("mdu_no_stall_idle", ctl(), 0);
        chk("mdu_stall_cnt", {16'd0, stall_cnt}, 3);
        tick(); clr();
        mid(); chk("mdu_done_t5", {31'd0, mdu_done}, 0);

        // Branch beats load hazard
        mem_readE = 1; rdE = 5; rsD2 = 5; branch_takenE = 1;
        mid(); chk("prio_ctl", ctl(), 32'h3);
        tick(); clr();
        mid(); chk("prio_cnt", {16'd0, stall_cnt}, 3);

        // Reset mid-operation
        mdu_startE = 1; rdE = 4; mdu_lat = 10;
        tick(); clr();
        tick(); tick();
        rst_n = 1'b0;
        mid();
        chk("rstmid_busy", {31'd0, mdu_busy}, 0);
        chk("rstmid_cnt", {16'd0, stall_cnt}, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick(); mid();
            chk("rstmid_no_done", {31'd0, mdu_done}, 0);
        end

        // Latency 0 behaves as 1
        mdu_startE = 1; rdE = 2; mdu_lat = 0;
        tick(); clr();
        mid(); chk("lat0_busy", {31'd0, mdu_busy}, 1); chk("lat0_nodone", {31'd0, mdu_done}, 0);
        tick();
        mid(); chk("lat0_done", {31'd0, mdu_done}, 1); chk("lat0_idle", {31'd0, mdu_busy}, 0);

        // Back-to-back issue on the done cycle
        mdu_startE = 1; rdE = 3; mdu_lat = 2;
        tick(); clr();
        tick(); tick();
        mdu_startE = 1; rdE = 6; mdu_lat = 1;
        mid(); chk("b2b_done1", {31'd0, mdu_done}, 1);
        tick(); clr();
        mid(); chk("b2b_busy2", {31'd0, mdu_busy}, 1); chk("b2b_nodone", {31'd0, mdu_done}, 0);
        tick();
        mid(); chk("b2b_done2", {31'd0, mdu_done}, 1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            tick();
            rsD1          = 5'($urandom_range(0, 3));
            rsD2          = 5'($urandom_range(0, 3));
            rdE           = 5'($urandom_range(0, 3));
            mem_readE     = ($urandom_range(0, 9) < 3);
            mdu_reqD      = ($urandom_range(0, 9) < 2);
            mdu_startE    = ($urandom_range(0, 99) < 15);
            mdu_lat       = 4'($urandom_range(0, 15));
            branch_takenE = ($urandom_range(0, 99) < 15);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
        end
        tick();
        clr();
        rst_n = 1'b1;

        // Saturation of the stall counter
        mem_readE = 1; rdE = 5; rsD1 = 5;
        repeat (65540) tick();
        mid(); chk("sat", {16'd0, stall_cnt}, 32'hFFFF);
        tick();
        mid(); chk("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
        clr();
        tick();
        mid();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
